// File: rtl/df_txn_tracker.sv
// df_txn_tracker: timestamps accepted inputs, reports per-transaction latency on output
// accept and raises a sticky finish. Define DF_TRACKER_TIMEOUT_EN to build the idle watchdog.
module df_txn_tracker #(
    parameter int EXPECTED_TXNS   = 4,
    parameter int CNT_WIDTH       = 32,
    parameter int MAX_OUTSTANDING = 8,
    parameter int TIMEOUT_CYCLES  = 10000
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             in_valid,
    input  logic                             in_ready,
    input  logic                             out_valid,
    input  logic                             out_ready,
    output logic                             finish,
    output logic [CNT_WIDTH-1:0]             txn_count,
    output logic [CNT_WIDTH-1:0]             cycle_count,
    output logic                             lat_valid,
    output logic [CNT_WIDTH-1:0]             lat_value,
    output logic [CNT_WIDTH-1:0]             lat_max,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
    output logic                             err_overflow,
    output logic                             err_underflow,
    output logic                             timeout
);
    localparam int AW = $clog2(MAX_OUTSTANDING);
    localparam int OW = AW + 1;
    localparam logic [AW:0]          DEPTH    = OW'(MAX_OUTSTANDING);
    localparam logic [CNT_WIDTH-1:0] EXP_LAST = CNT_WIDTH'(EXPECTED_TXNS - 1);

    typedef enum logic [1:0] {ST_RUN, ST_DONE, ST_TOUT} state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
    logic [CNT_WIDTH-1:0] txn_q, txn_d;
    logic                 lat_valid_q, lat_valid_d;
    logic [CNT_WIDTH-1:0] lat_value_q, lat_value_d;
    logic [CNT_WIDTH-1:0] lat_max_q, lat_max_d;
    logic                 ovf_q, ovf_d;
    logic                 udf_q, udf_d;
    logic                 finish_q, finish_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]          count_q, count_d;
    logic [CNT_WIDTH-1:0] ts_mem_q [MAX_OUTSTANDING];

    logic push_req, pop_req, fifo_empty, fifo_full;
    logic do_push, do_pop, tout_hit;
    logic [CNT_WIDTH-1:0] head_ts;

    assign push_req   = in_valid & in_ready;
    assign pop_req    = out_valid & out_ready;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH);
    assign head_ts    = ts_mem_q[rd_ptr_q];

    always_comb begin
        state_d     = state_q;
        cycle_d     = cycle_q + 1'b1;
        txn_d       = txn_q;
        lat_valid_d = 1'b0;
        lat_value_d = lat_value_q;
        lat_max_d   = lat_max_q;
        ovf_d       = ovf_q;
        udf_d       = udf_q;
        do_push     = 1'b0;
        do_pop      = 1'b0;

        if (pop_req) begin
            txn_d = (&txn_q) ? txn_q : txn_q + 1'b1;
            if (!fifo_empty) begin
                do_pop      = 1'b1;
                lat_value_d = cycle_q - head_ts;
                lat_valid_d = 1'b1;
            end else if (push_req) begin
                // Empty FIFO with a same-cycle push: the transaction passes straight through.
                lat_value_d = '0;
                lat_valid_d = 1'b1;
            end else begin
                udf_d = 1'b1;
            end
        end

        if (push_req && !(pop_req && fifo_empty)) begin
            if (fifo_full && !do_pop) begin
                ovf_d = 1'b1;
            end else begin
                do_push = 1'b1;
            end
        end

        if (lat_valid_d && (lat_value_d > lat_max_q)) begin
            lat_max_d = lat_value_d;
        end

        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_RUN: begin
                if (pop_req && (txn_q == EXP_LAST)) begin
                    state_d = ST_DONE;
                end else if (tout_hit) begin
                    state_d = ST_TOUT;
                end
            end
            default: state_d = state_q;
        endcase
        finish_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_RUN;
            cycle_q     <= '0;
            txn_q       <= '0;
            lat_valid_q <= 1'b0;
            lat_value_q <= '0;
            lat_max_q   <= '0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            finish_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            cycle_q     <= cycle_d;
            txn_q       <= txn_d;
            lat_valid_q <= lat_valid_d;
            lat_value_q <= lat_value_d;
            lat_max_q   <= lat_max_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
            finish_q    <= finish_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Timestamp storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clock) begin
        if (!reset && do_push) begin
            ts_mem_q[wr_ptr_q] <= cycle_q;
        end
    end

`ifdef DF_TRACKER_TIMEOUT_EN
    localparam logic [CNT_WIDTH-1:0] TOUT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);

    logic [CNT_WIDTH-1:0] idle_q, idle_d;
    logic                 timeout_q;

    always_comb begin
        idle_d = idle_q;
        if (state_q == ST_RUN) begin
            idle_d = pop_req ? '0 : idle_q + 1'b1;
        end
    end

    assign tout_hit = (state_q == ST_RUN) && !pop_req && (idle_d == TOUT_LIMIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            timeout_q <= (state_d == ST_TOUT);
        end
    end

    assign timeout = timeout_q;
`else
    // Watchdog absent: the limit only appears so the parameter stays referenced.
    assign tout_hit = 1'b0 & (TIMEOUT_CYCLES != 0);
    assign timeout  = 1'b0;
`endif

    assign finish        = finish_q;
    assign txn_count     = txn_q;
    assign cycle_count   = cycle_q;
    assign lat_valid     = lat_valid_q;
    assign lat_value     = lat_value_q;
    assign lat_max       = lat_max_q;
    assign outstanding   = count_q;
    assign err_overflow  = ovf_q;
    assign err_underflow = udf_q;

endmodule

// File: tb/tb_df_txn_tracker.sv
// Bench for df_txn_tracker: queue-based reference model checked every cycle plus directed literals.
module tb_df_txn_tracker;
    localparam int EXP   = 4;
    localparam int CW    = 8;
    localparam int DEPTH = 8;
    localparam int TOUT  = 20;
    localparam int MOD   = 256;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0, in_ready = 1'b0, out_valid = 1'b0, out_ready = 1'b0;
    logic          finish, lat_valid, err_overflow, err_underflow, timeout;
    logic [CW-1:0] txn_count, cycle_count, lat_value, lat_max;
    logic [3:0]    outstanding;

    always #5 clock = ~clock;

    df_txn_tracker #(
        .EXPECTED_TXNS  (EXP),
        .CNT_WIDTH      (CW),
        .MAX_OUTSTANDING(DEPTH),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .finish       (finish),
        .txn_count    (txn_count),
        .cycle_count  (cycle_count),
        .lat_valid    (lat_valid),
        .lat_value    (lat_value),
        .lat_max      (lat_max),
        .outstanding  (outstanding),
        .err_overflow (err_overflow),
        .err_underflow(err_underflow),
        .timeout      (timeout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: timestamps in a queue, everything else as plain integers.
    int m_q[$];
    int m_cycle = 0, m_txn = 0, m_lat_value = 0, m_lat_max = 0, m_lat = 0;
    bit m_lat_valid = 0, m_ovf = 0, m_udf = 0, m_finish = 0, m_timeout = 0;
    bit m_push, m_pop, m_bypass, m_was_run, started = 0;
`ifdef DF_TRACKER_TIMEOUT_EN
    int m_idle = 0;
`endif

    always @(posedge clock) begin
        started = 1'b1;
        if (reset) begin
            m_q.delete();
            m_cycle = 0; m_txn = 0; m_lat_value = 0; m_lat_max = 0;
            m_lat_valid = 0; m_ovf = 0; m_udf = 0; m_finish = 0; m_timeout = 0;
`ifdef DF_TRACKER_TIMEOUT_EN
            m_idle = 0;
`endif
        end else begin
            m_was_run   = !m_finish;
            m_push      = in_valid && in_ready;
            m_pop       = out_valid && out_ready;
            m_bypass    = 0;
            m_lat_valid = 0;
            if (m_pop) begin
                if (m_txn < MOD - 1) m_txn++;
                if (m_q.size() > 0) begin
                    m_lat = (m_cycle - m_q.pop_front()) & (MOD - 1);
                    m_lat_valid = 1;
                end else if (m_push) begin
                    m_lat = 0;
                    m_lat_valid = 1;
                    m_bypass = 1;
                end else begin
                    m_udf = 1;
                end
            end
            if (m_push && !m_bypass) begin
                if (m_q.size() >= DEPTH) m_ovf = 1;
                else m_q.push_back(m_cycle);
            end
            if (m_lat_valid) begin
                m_lat_value = m_lat;
                if (m_lat > m_lat_max) m_lat_max = m_lat;
            end
            if (m_was_run && m_txn >= EXP) m_finish = 1;
`ifdef DF_TRACKER_TIMEOUT_EN
            if (m_was_run && !m_finish) begin
                m_idle = m_pop ? 0 : m_idle + 1;
                if (m_idle >= TOUT) begin
                    m_timeout = 1;
                    m_finish  = 1;
                end
            end
`endif
            m_cycle = (m_cycle + 1) % MOD;
        end
    end

    always @(negedge clock) begin
        if (started) begin
            chk("cycle_count",   cycle_count,   m_cycle);
            chk("txn_count",     txn_count,     m_txn);
            chk("lat_valid",     lat_valid,     m_lat_valid);
            chk("lat_value",     lat_value,     m_lat_value);
            chk("lat_max",       lat_max,       m_lat_max);
            chk("outstanding",   outstanding,   m_q.size());
            chk("err_overflow",  err_overflow,  m_ovf);
            chk("err_underflow", err_underflow, m_udf);
            chk("finish",        finish,        m_finish);
            chk("timeout",       timeout,       m_timeout);
        end
    end

    task automatic tick(input bit iv, input bit ir, input bit ov, input bit orr);
        in_valid = iv; in_ready = ir; out_valid = ov; out_ready = orr;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(0, 0, 0, 0);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        reset = 1'b0;
        $display("[TB] txn: reset");
        chk("rst_cycle", cycle_count, 0);
        chk("rst_finish", finish, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_txn", txn_count, 0);

        // Inputs at cycles 2..5, outputs at 7..10: latency 5 each.
        tick(1, 0, 0, 0);
        tick(0, 1, 0, 0);
        repeat (4) tick(1, 1, 0, 0);
        tick(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 1, 1);
            $display("[TB] txn: basic out %0d lat=%0d", i, lat_value);
            chk("basic_lat_valid", lat_valid, 1);
            chk("basic_lat_value", lat_value, 5);
            chk("basic_txn", txn_count, i + 1);
            chk("basic_finish", finish, (i == 3) ? 1 : 0);
            if (i == 0) chk("basic_outstanding", outstanding, 3);
        end
        chk("basic_lat_max", lat_max, 5);
        chk("basic_cycle", cycle_count, 11);
        tick(0, 0, 0, 0);
        chk("basic_pulse_end", lat_valid, 0);
        chk("basic_finish_sticky", finish, 1);

        // Nine pushes into an eight-deep FIFO; the ninth is dropped.
        do_reset();
        repeat (9) tick(1, 1, 0, 0);
        $display("[TB] txn: overflow outstanding=%0d ovf=%0d", outstanding, err_overflow);
        chk("ovf_outstanding", outstanding, 8);
        chk("ovf_flag", err_overflow, 1);
        chk("ovf_no_udf", err_underflow, 0);
        tick(0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            tick(0, 0, 1, 1);
            $display("[TB] txn: drain %0d lat=%0d", i, lat_value);
            chk("drain_lat_value", lat_value, 10);
        end
        chk("drain_outstanding", outstanding, 0);
        chk("drain_txn", txn_count, 8);

        // Simultaneous push and pop with an empty FIFO.
        do_reset();
        tick(1, 1, 1, 1);
        $display("[TB] txn: bypass lat=%0d", lat_value);
        chk("byp_lat_valid", lat_valid, 1);
        chk("byp_lat_value", lat_value, 0);
        chk("byp_outstanding", outstanding, 0);
        chk("byp_txn", txn_count, 1);
        chk("byp_udf", err_underflow, 0);

        // Output accept with nothing outstanding.
        do_reset();
        tick(0, 0, 1, 1);
        $display("[TB] txn: underflow udf=%0d", err_underflow);
        chk("udf_flag", err_underflow, 1);
        chk("udf_txn", txn_count, 1);
        chk("udf_no_pulse", lat_valid, 0);

        // Simultaneous push and pop with a full FIFO.
        do_reset();
        repeat (8) tick(1, 1, 0, 0);
        tick(1, 1, 1, 1);
        $display("[TB] txn: full push+pop lat=%0d outstanding=%0d", lat_value, outstanding);
        chk("full_outstanding", outstanding, 8);
        chk("full_no_ovf", err_overflow, 0);
        chk("full_no_udf", err_underflow, 0);
        chk("full_lat_value", lat_value, 8);

        // Counter wrap: input at 250, output at 4.
        do_reset();
        repeat (250) tick(0, 0, 0, 0);
        chk("wrap_start", cycle_count, 250);
        tick(1, 1, 0, 0);
        repeat (9) tick(0, 0, 0, 0);
        chk("wrap_cycle", cycle_count, 4);
        tick(0, 0, 1, 1);
        $display("[TB] txn: wrap lat=%0d", lat_value);
        chk("wrap_lat_value", lat_value, 10);
        chk("wrap_lat_valid", lat_valid, 1);

        // Mid-run reset with timestamps outstanding.
        tick(1, 1, 0, 0);
        tick(1, 1, 0, 0);
        do_reset();
        $display("[TB] txn: mid-run reset");
        chk("mrst_outstanding", outstanding, 0);
        chk("mrst_cycle", cycle_count, 0);
        chk("mrst_lat_max", lat_max, 0);
        chk("mrst_txn", txn_count, 0);

`ifdef DF_TRACKER_TIMEOUT_EN
        repeat (19) tick(0, 0, 0, 0);
        chk("tout_early", timeout, 0);
        tick(0, 0, 0, 0);
        $display("[TB] txn: watchdog timeout=%0d finish=%0d", timeout, finish);
        chk("tout_flag", timeout, 1);
        chk("tout_finish", finish, 1);
        do_reset();
        chk("tout_rst_flag", timeout, 0);
        chk("tout_rst_finish", finish, 0);
        chk("tout_rst_cycle", cycle_count, 0);
`else
        repeat (25) tick(0, 0, 0, 0);
        $display("[TB] txn: idle, no watchdog");
        chk("idle_timeout", timeout, 0);
        chk("idle_finish", finish, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
